// File: rtl/bank_conflict_scheduler_if.sv
// Operand-scheduler bus: request handshake, bank steal inputs, per-bank
// memory address/enable/data lines and the captured-operand handshake.
// The master side issues requests and models memory; the slave side is
// the scheduler.
interface bank_conflict_scheduler_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                       req_valid;
   logic                       req_ready;
   logic [2:0]                 req_mask;
   logic [ADDR_WIDTH+1:0]      a_addr;
   logic [ADDR_WIDTH+1:0]      b_addr;
   logic [ADDR_WIDTH+1:0]      c_addr;
   logic                       ctrl_req;
   logic [ADDR_WIDTH-1:0]      ctrl_addr;
   logic                       uinst_req;
   logic [ADDR_WIDTH-1:0]      uinst_addr;
   logic [4*ADDR_WIDTH-1:0]    bank_addr;
   logic [3:0]                 bank_en;
   logic [4*64-1:0]            bank_rd_data;
   logic                       op_valid;
   logic                       op_ready;
   logic [63:0]                a_data;
   logic [63:0]                b_data;
   logic [63:0]                c_data;
   logic [15:0]                stall_cnt;

   modport master (
      output req_valid, req_mask, a_addr, b_addr, c_addr,
             ctrl_req, ctrl_addr, uinst_req, uinst_addr,
             bank_rd_data, op_ready,
      input  req_ready, bank_addr, bank_en, op_valid,
             a_data, b_data, c_data, stall_cnt
   );

   modport slave (
      input  req_valid, req_mask, a_addr, b_addr, c_addr,
             ctrl_req, ctrl_addr, uinst_req, uinst_addr,
             bank_rd_data, op_ready,
      output req_ready, bank_addr, bank_en, op_valid,
             a_data, b_data, c_data, stall_cnt
   );
endinterface

// File: rtl/bank_conflict_scheduler.sv
// Bank conflict scheduler: fetches up to three operands (A/B/C) from a
// four-bank scratch memory, serialising reads that collide on a bank and
// yielding bank 0 to the control port and bank 2 to the micro-instruction
// fetch whenever they ask. Bank index is the top two operand address bits.
// Optional feature macro: BANK_CONFLICT_STATS_EN (stall cycle counter).
module bank_conflict_scheduler #(
   parameter int ADDR_WIDTH = 12,
   parameter int RD_LAT     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bank_conflict_scheduler_if.slave bus
);

   localparam int OPW  = ADDR_WIDTH + 2;
   localparam int OP_A = 0;
   localparam int OP_B = 1;
   localparam int OP_C = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [2:0]               pending_q, pending_d;
   logic [2:0][OPW-1:0]      addr_q;
   logic [2:0][63:0]         data_q;
   logic [RD_LAT-1:0][2:0]   ret_q;

   logic                     accept;
   logic                     ret_empty;
   logic [3:0]               ovr_en;
   logic [3:0][ADDR_WIDTH-1:0] ovr_addr;
   logic [3:0]               bank_avail;
   logic [3:0]               pick_valid;
   logic [3:0][OPW-1:0]      pick_addr;
   logic [2:0]               issue;
   logic [2:0][63:0]         ret_word;

   // Steal sources: control port owns bank 0, micro-instruction fetch bank 2
   assign ovr_en     = {1'b0, bus.uinst_req, 1'b0, bus.ctrl_req};
   assign ovr_addr   = {{ADDR_WIDTH{1'b0}}, bus.uinst_addr,
                        {ADDR_WIDTH{1'b0}}, bus.ctrl_addr};
   assign bank_avail = ~ovr_en;
   assign ret_empty  = (ret_q == '0);

   genvar gi;

   // Per-bank arbitration (B > A > C) and bank port driving; steals win
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic hit_a, hit_b, hit_c;
         assign hit_a = pending_q[OP_A] && (addr_q[OP_A][OPW-1:ADDR_WIDTH] == 2'(gi));
         assign hit_b = pending_q[OP_B] && (addr_q[OP_B][OPW-1:ADDR_WIDTH] == 2'(gi));
         assign hit_c = pending_q[OP_C] && (addr_q[OP_C][OPW-1:ADDR_WIDTH] == 2'(gi));
         assign pick_valid[gi] = (state_q == S_ISSUE) && bank_avail[gi]
                                 && (hit_a || hit_b || hit_c);
         assign pick_addr[gi]  = hit_b ? addr_q[OP_B]
                               : (hit_a ? addr_q[OP_A] : addr_q[OP_C]);
         assign bus.bank_en[gi] = ovr_en[gi] | pick_valid[gi];
         assign bus.bank_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            ovr_en[gi]     ? ovr_addr[gi] :
            pick_valid[gi] ? pick_addr[gi][ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};
      end
   endgenerate

   // Per-operand issue: an operand goes out when its bank's winner carries
   // the same full address (covers both the winner and shared reads)
   generate
      for (gi = 0; gi < 3; gi++) begin : g_op
         logic [1:0] bank_sel;
         assign bank_sel     = addr_q[gi][OPW-1:ADDR_WIDTH];
         assign issue[gi]    = pending_q[gi] && pick_valid[bank_sel]
                               && (addr_q[gi] == pick_addr[bank_sel]);
         assign ret_word[gi] = bus.bank_rd_data[{bank_sel, 6'd0} +: 64];
      end
   endgenerate

   // Next-state and handshake outputs
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      accept        = 1'b0;
      bus.req_ready = 1'b0;
      bus.op_valid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept    = 1'b1;
               pending_d = bus.req_mask;
               state_d   = (bus.req_mask == 3'b000) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            pending_d = pending_q & ~issue;
            if (pending_d == 3'b000) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ret_empty) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            bus.op_valid = 1'b1;
            if (bus.op_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, pending set, latched addresses and return pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         addr_q    <= '0;
         ret_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (accept) begin
            addr_q <= {bus.c_addr, bus.b_addr, bus.a_addr};
         end
         ret_q[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) begin
            ret_q[i] <= ret_q[i-1];
         end
      end
   end

   // Operand registers: cleared when masked off, loaded when their read returns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (accept && !bus.req_mask[i]) begin
               data_q[i] <= '0;
            end else if (ret_q[RD_LAT-1][i]) begin
               data_q[i] <= ret_word[i];
            end
         end
      end
   end

   assign bus.a_data = data_q[OP_A];
   assign bus.b_data = data_q[OP_B];
   assign bus.c_data = data_q[OP_C];

`ifdef BANK_CONFLICT_STATS_EN
   logic [15:0] stall_cnt_q;
   logic        stall_evt;

   assign stall_evt = (state_q == S_ISSUE) && ((pending_q & ~issue) != 3'b000);

   // Saturating count of issue cycles that left an operand waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bank_conflict_scheduler.sv
// Directed bench for bank_conflict_scheduler: table of request vectors plus
// hand-written steal, back-pressure and mid-operation reset sequences.
module tb_bank_conflict_scheduler;

   localparam int AW     = 12;
   localparam int RD_LAT = 1;
`ifdef BANK_CONFLICT_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   exp_stall;

   bank_conflict_scheduler_if #(.ADDR_WIDTH(AW)) bus_if ();

   bank_conflict_scheduler #(
      .ADDR_WIDTH (AW),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: each bank returns a word tagged with bank number and address
   function automatic logic [63:0] mem_word(input int k, input logic [AW-1:0] a);
      return {16'hCAFE, 14'd0, 2'(k), 20'd0, a};
   endfunction

   logic [RD_LAT-1:0][3:0][63:0] rd_pipe;
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         rd_pipe[0][k] <= bus_if.bank_en[k] ? mem_word(k, bus_if.bank_addr[k*AW +: AW]) : 64'd0;
      end
      for (int s = 1; s < RD_LAT; s++) begin
         rd_pipe[s] <= rd_pipe[s-1];
      end
   end
   assign bus_if.bank_rd_data = rd_pipe[RD_LAT-1];

   typedef struct {
      string        name;
      logic [2:0]   mask;
      logic [13:0]  a, b, c;
      logic [3:0]   en;
      int           lat;
      logic [63:0]  ea, eb, ec;
      int           stall;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic start_req(input logic [2:0] mask, input logic [13:0] a,
                            input logic [13:0] b, input logic [13:0] c, input string tag);
      @(negedge clk);
      bus_if.req_mask  = mask;
      bus_if.a_addr    = a;
      bus_if.b_addr    = b;
      bus_if.c_addr    = c;
      bus_if.req_valid = 1'b1;
      check({tag, " req_ready"}, 64'(bus_if.req_ready), 64'd1);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus_if.op_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_ops(input string tag);
      @(negedge clk);
      bus_if.op_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.op_ready = 1'b0;
      check({tag, " op_valid drop"}, 64'(bus_if.op_valid), 64'd0);
   endtask

   initial begin
      int lat;
      n_checks  = 0;
      n_errors  = 0;
      exp_stall = 0;

      vecs[0] = '{"no_conflict", 3'b111, 14'h0010, 14'h1020, 14'h2030, 4'b0111, 3,
                  64'hCAFE0000_00000010, 64'hCAFE0001_00000020, 64'hCAFE0002_00000030, 0};
      vecs[1] = '{"all_bank0",   3'b111, 14'h0010, 14'h0020, 14'h0030, 4'b0001, 5,
                  64'hCAFE0000_00000010, 64'hCAFE0000_00000020, 64'hCAFE0000_00000030, 2};
      vecs[2] = '{"shared_ac",   3'b101, 14'h3040, 14'h1111, 14'h3040, 4'b1000, 3,
                  64'hCAFE0003_00000040, 64'd0, 64'hCAFE0003_00000040, 0};
      vecs[3] = '{"mask_zero",   3'b000, 14'h0011, 14'h1022, 14'h2033, 4'b0000, 0,
                  64'd0, 64'd0, 64'd0, 0};

      rst_n             = 1'b0;
      bus_if.req_valid  = 1'b0;
      bus_if.req_mask   = 3'b000;
      bus_if.a_addr     = '0;
      bus_if.b_addr     = '0;
      bus_if.c_addr     = '0;
      bus_if.ctrl_req   = 1'b0;
      bus_if.ctrl_addr  = '0;
      bus_if.uinst_req  = 1'b0;
      bus_if.uinst_addr = '0;
      bus_if.op_ready   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst req_ready", 64'(bus_if.req_ready), 64'd1);
      check("rst op_valid",  64'(bus_if.op_valid),  64'd0);
      check("rst bank_en",   64'(bus_if.bank_en),   64'd0);
      check("rst bank_addr", 64'(bus_if.bank_addr), 64'd0);
      check("rst a_data",    bus_if.a_data,         64'd0);
      check("rst stall_cnt", 64'(bus_if.stall_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Micro-instruction steal drives bank 2 even while idle
      @(negedge clk);
      bus_if.uinst_req  = 1'b1;
      bus_if.uinst_addr = 12'h123;
      #1;
      check("idle uinst bank_en",    64'(bus_if.bank_en),             64'h4);
      check("idle uinst bank2 addr", 64'(bus_if.bank_addr[2*AW +: AW]), 64'h123);
      bus_if.uinst_req = 1'b0;

      // Table-driven requests
      for (int i = 0; i < 4; i++) begin
         start_req(vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].name);
         check({vecs[i].name, " first bank_en"}, 64'(bus_if.bank_en), 64'(vecs[i].en));
         wait_valid(lat);
         check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
         check({vecs[i].name, " a_data"}, bus_if.a_data, vecs[i].ea);
         check({vecs[i].name, " b_data"}, bus_if.b_data, vecs[i].eb);
         check({vecs[i].name, " c_data"}, bus_if.c_data, vecs[i].ec);
         exp_stall += STATS * vecs[i].stall;
         check({vecs[i].name, " stall_cnt"}, 64'(bus_if.stall_cnt), 64'(exp_stall));
         release_ops(vecs[i].name);
      end

      // Control port holds bank 0 for three cycles right after acceptance
      start_req(3'b001, 14'h0010, 14'h0000, 14'h0000, "steal");
      bus_if.ctrl_req  = 1'b1;
      bus_if.ctrl_addr = 12'h5A5;
      #1;
      check("steal bank0 addr c0", 64'(bus_if.bank_addr[AW-1:0]), 64'h5A5);
      check("steal bank0 en c0",   64'(bus_if.bank_en[0]),        64'd1);
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("steal bank0 addr c%0d", c), 64'(bus_if.bank_addr[AW-1:0]), 64'h5A5);
      end
      @(posedge clk);
      #1;
      bus_if.ctrl_req = 1'b0;
      #1;
      check("steal issue addr", 64'(bus_if.bank_addr[AW-1:0]), 64'h010);
      check("steal issue en",   64'(bus_if.bank_en),           64'h1);
      wait_valid(lat);
      check("steal latency", 64'(lat + 3), 64'd6);
      check("steal a_data", bus_if.a_data, 64'hCAFE0000_00000010);
      exp_stall += STATS * 3;
      check("steal stall_cnt", 64'(bus_if.stall_cnt), 64'(exp_stall));
      release_ops("steal");

      // Back-pressure: operands held while op_ready stays low
      start_req(3'b111, 14'h0010, 14'h1020, 14'h2030, "hold");
      wait_valid(lat);
      check("hold latency", 64'(lat), 64'd3);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus_if.req_valid = 1'b1;
         bus_if.req_mask  = 3'b010;
         bus_if.b_addr    = 14'h2222;
         @(posedge clk);
         #1;
         bus_if.req_valid = 1'b0;
         check($sformatf("hold op_valid c%0d", c),  64'(bus_if.op_valid),  64'd1);
         check($sformatf("hold req_ready c%0d", c), 64'(bus_if.req_ready), 64'd0);
         check($sformatf("hold b_data c%0d", c),    bus_if.b_data, 64'hCAFE0001_00000020);
      end
      release_ops("hold");
      check("hold idle req_ready", 64'(bus_if.req_ready), 64'd1);
      @(posedge clk);
      #1;
      check("hold no accept", 64'(bus_if.op_valid), 64'd0);
      check("hold c_data kept", bus_if.c_data, 64'hCAFE0002_00000030);

      // Asynchronous reset while waiting on the last conflicting read
      start_req(3'b111, 14'h0010, 14'h0020, 14'h0030, "rstwait");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstwait req_ready", 64'(bus_if.req_ready), 64'd1);
      check("rstwait op_valid",  64'(bus_if.op_valid),  64'd0);
      check("rstwait bank_en",   64'(bus_if.bank_en),   64'd0);
      check("rstwait a_data",    bus_if.a_data,         64'd0);
      check("rstwait b_data",    bus_if.b_data,         64'd0);
      check("rstwait stall_cnt", 64'(bus_if.stall_cnt), 64'd0);
      exp_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      start_req(3'b111, 14'h0010, 14'h1020, 14'h2030, "after_rst");
      wait_valid(lat);
      check("after_rst latency", 64'(lat), 64'd3);
      check("after_rst a_data", bus_if.a_data, 64'hCAFE0000_00000010);
      check("after_rst c_data", bus_if.c_data, 64'hCAFE0002_00000030);
      check("after_rst stall_cnt", 64'(bus_if.stall_cnt), 64'(exp_stall));
      release_ops("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
